// File: rtl/traffic_pkg.sv
// Shared constants for the traffic-light slice: FSM state codes, counter load codes
// and light encodings.
package traffic_pkg;

  // SY_RUN takes code 8, so the state (and phase) is four bits wide.
  typedef enum logic [3:0] {
    StIdle   = 4'd0,
    StMgLoad = 4'd1,
    StMgRun  = 4'd2,
    StMyLoad = 4'd3,
    StMyRun  = 4'd4,
    StSgLoad = 4'd5,
    StSgRun  = 4'd6,
    StSyLoad = 4'd7,
    StSyRun  = 4'd8
  } state_e;

  localparam logic [2:0] InitNone   = 3'b000;
  localparam logic [2:0] InitRed    = 3'b100;
  localparam logic [2:0] InitYellow = 3'b010;
  localparam logic [2:0] InitGreen  = 3'b001;

  localparam logic [2:0] LightRed    = 3'b100;
  localparam logic [2:0] LightYellow = 3'b010;
  localparam logic [2:0] LightGreen  = 3'b001;

  typedef struct packed {
    logic [2:0] main_l;
    logic [2:0] side_l;
  } lights_t;

  // Unknown codes show all-red.
  function automatic lights_t lights_of(state_e st);
    lights_t l;
    l = '{main_l: LightRed, side_l: LightRed};
    case (st)
      StMgLoad, StMgRun: l = '{main_l: LightGreen,  side_l: LightRed};
      StMyLoad, StMyRun: l = '{main_l: LightYellow, side_l: LightRed};
      StSgLoad, StSgRun: l = '{main_l: LightRed,    side_l: LightGreen};
      StSyLoad, StSyRun: l = '{main_l: LightRed,    side_l: LightYellow};
      default:           l = '{main_l: LightRed,    side_l: LightRed};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller (master) and its environment:
// the phase counter, pedestrian button and light drivers.
interface traffic_light_ctrl_if #(
  parameter int unsigned pINIT_WIDTH = 3
);
  logic                   en;
  logic                   ped_req;
  logic                   last;
  logic [pINIT_WIDTH-1:0] init;
  logic                   cnt_en;
  logic [2:0]             main_light;
  logic [2:0]             side_light;
  logic                   ped_walk;
  logic [3:0]             phase;

  modport master (
    input  en, ped_req, last,
    output init, cnt_en, main_light, side_light, ped_walk, phase
  );

  modport slave (
    output en, ped_req, last,
    input  init, cnt_en, main_light, side_light, ped_walk, phase
  );
endinterface

// File: rtl/traffic_light_ctrl_min_green_timer.sv
// Saturating count of enabled main-green cycles, compared against the minimum green
// time that must pass before a pedestrian may cut main green short.
module min_green_timer #(
  parameter int unsigned pCNT_WIDTH = 5,
  parameter int unsigned pMIN_GREEN = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clear,
  input  logic run,
  output logic min_met
);
  // The MG_RUN cycle being evaluated counts toward the minimum, hence the -1.
  localparam logic [pCNT_WIDTH-1:0] Thresh = pCNT_WIDTH'(pMIN_GREEN - 1);

  logic [pCNT_WIDTH-1:0] elapsed_q, elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (en) begin
      if (clear) begin
        elapsed_d = '0;
      end else if (run && (elapsed_q != '1)) begin
        elapsed_d = elapsed_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign min_met = (elapsed_q >= Thresh);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: drives the phase counter's load/enable, the main
// and side lights and the walk signal, with a pedestrian-requested early end of main green.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned pCNT_WIDTH  = 5,
  parameter int unsigned pINIT_WIDTH = 3,
  parameter int unsigned pMIN_GREEN  = 5
) (
  input logic                  clk,
  input logic                  rst,
  traffic_light_ctrl_if.master bus
);
  state_e                 state_q, state_d;
  logic                   ped_pend_q, ped_pend_d;
  logic                   min_met;
  logic [pINIT_WIDTH-1:0] init_dec;
  lights_t                lights;

  min_green_timer #(
    .pCNT_WIDTH(pCNT_WIDTH),
    .pMIN_GREEN(pMIN_GREEN)
  ) u_min_green_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (bus.en),
    .clear  (state_q == StMgLoad),
    .run    (state_q == StMgRun),
    .min_met(min_met)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (bus.en) state_d = StMgLoad;
      StMgLoad: if (bus.en) state_d = StMgRun;
      StMgRun:  if (bus.en && (bus.last || (ped_pend_q && min_met))) state_d = StMyLoad;
      StMyLoad: if (bus.en) state_d = StMyRun;
      StMyRun:  if (bus.en && bus.last) state_d = StSgLoad;
      StSgLoad: if (bus.en) state_d = StSgRun;
      StSgRun:  if (bus.en && bus.last) state_d = StSyLoad;
      StSyLoad: if (bus.en) state_d = StSyRun;
      StSyRun:  if (bus.en && bus.last) state_d = StMgLoad;
      default:  state_d = StIdle;
    endcase
  end

  // Serving the crossing (entering side green) wins over a same-cycle new request.
  always_comb begin
    ped_pend_d = ped_pend_q;
    if (bus.en) begin
      if ((state_d == StSgLoad) && (state_q != StSgLoad)) begin
        ped_pend_d = 1'b0;
      end else if (bus.ped_req && (state_q != StIdle)) begin
        ped_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      ped_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ped_pend_q <= ped_pend_d;
    end
  end

  // A LOAD state held with en low keeps its pulse pending until en returns.
  always_comb begin
    init_dec = InitNone;
    if (bus.en) begin
      case (state_q)
        StMgLoad, StSgLoad: init_dec = InitGreen;
        StMyLoad, StSyLoad: init_dec = InitYellow;
        default:            init_dec = InitNone;
      endcase
    end
  end

  assign lights         = lights_of(state_q);
  assign bus.init       = init_dec;
  assign bus.cnt_en     = bus.en && (state_q != StIdle);
  assign bus.main_light = lights.main_l;
  assign bus.side_light = lights.side_l;
  assign bus.ped_walk   = (state_q == StSgLoad) || (state_q == StSgRun);
  assign bus.phase      = state_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: scenario tasks compare the DUT each cycle
// against a phase-table reference model driven by a simple phase-counter model.
module tb_traffic_light_ctrl;
  localparam int unsigned MinGreen = 5;
  localparam logic [14:0] ResetVec = 15'b000_0_100_100_0_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  traffic_light_ctrl_if #(.pINIT_WIDTH(3)) bus ();

  traffic_light_ctrl #(
    .pCNT_WIDTH (5),
    .pINIT_WIDTH(3),
    .pMIN_GREEN (MinGreen)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_chk;
  int n_err;

  // Reference model: spec phase code, pending request, enabled cycles since MG_LOAD.
  int m_code;
  bit m_pend;
  int m_mg;
  // Phase counter model: enabled cycles since the last load, and the loaded length.
  bit c_active;
  int c_cnt;
  int c_len;
  int g_len;
  int y_len;
  bit rand_len;
  bit cur_en, cur_req, cur_last;

  logic [2:0] main_tbl [9] = '{3'b100, 3'b001, 3'b001, 3'b010, 3'b010,
                               3'b100, 3'b100, 3'b100, 3'b100};
  logic [2:0] side_tbl [9] = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                               3'b001, 3'b001, 3'b010, 3'b010};

  function automatic logic [14:0] dut_vec();
    return {bus.init, bus.cnt_en, bus.main_light, bus.side_light, bus.ped_walk, bus.phase};
  endfunction

  function automatic logic [14:0] exp_vec();
    logic [2:0] ini;
    ini = 3'b000;
    if (cur_en && (m_code == 1 || m_code == 5)) ini = 3'b001;
    if (cur_en && (m_code == 3 || m_code == 7)) ini = 3'b010;
    return {ini, (cur_en && m_code != 0), main_tbl[m_code], side_tbl[m_code],
            (m_code == 5 || m_code == 6), 4'(m_code)};
  endfunction

  task automatic model_reset();
    m_code = 0; m_pend = 0; m_mg = 0; c_active = 0; c_cnt = 0;
  endtask

  // Apply inputs just after a falling edge; inj forces a spurious last outside RUN.
  task automatic drive(input bit e, input bit r, input bit inj);
    bit run_st;
    run_st   = (m_code == 2 || m_code == 4 || m_code == 6 || m_code == 8);
    cur_en   = e;
    cur_req  = r;
    cur_last = (run_st && c_active && c_cnt >= c_len) || (inj && !run_st);
    bus.en = e; bus.ped_req = r; bus.last = cur_last;
    #1;
  endtask

  // Step the model over the coming rising edge and wait for the next falling edge.
  task automatic adv();
    int nxt;
    bit ld;
    nxt = m_code;
    ld  = (m_code == 1 || m_code == 3 || m_code == 5 || m_code == 7);
    if (cur_en) begin
      if (m_code == 0 || ld) nxt = m_code + 1;
      else if (m_code == 2 && (cur_last || (m_pend && m_mg >= int'(MinGreen)))) nxt = 3;
      else if (cur_last) nxt = (m_code == 8) ? 1 : m_code + 1;
      if (nxt == 5 && m_code != 5) m_pend = 0;
      else if (cur_req && m_code != 0) m_pend = 1;
      if (nxt == 1) m_mg = 0;
      else if (m_mg < 1000) m_mg++;
      if (ld) begin
        if (rand_len) begin
          g_len = $urandom_range(1, 10);
          y_len = $urandom_range(1, 4);
        end
        c_active = 1;
        c_cnt    = 1;
        c_len    = (m_code == 1 || m_code == 5) ? g_len : y_len;
      end else if (c_active) begin
        c_cnt++;
      end
      m_code = nxt;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.ped_req = 1'b0; bus.last = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.ped_req = 1'b0; bus.last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (dut_vec() !== ResetVec) begin
      n_err++;
      $display("FAIL reset_held got=%b exp=%b", dut_vec(), ResetVec);
    end
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      adv();
    end
  endtask

  task automatic test_full_cycle();
    logic [2:0] seen [$];
    logic [2:0] exp_init [5] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001};
    do_reset();
    g_len = 15; y_len = 3;
    for (int i = 0; i < 45; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL full_cycle cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (bus.init !== 3'b000) seen.push_back(bus.init);
      adv();
    end
    n_chk++;
    if (seen.size() != 5) begin
      n_err++;
      $display("FAIL full_cycle_pulses got=%0d exp=5", seen.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        n_chk++;
        if (seen[k] !== exp_init[k]) begin
          n_err++;
          $display("FAIL full_cycle_init[%0d] got=%b exp=%b", k, seen[k], exp_init[k]);
        end
      end
    end
  endtask

  task automatic test_ped_early_exit();
    int my_at;
    my_at = -1;
    do_reset();
    g_len = 15; y_len = 3;
    for (int i = 0; i < 70; i++) begin
      drive(1'b1, (i == 3), 1'b0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL ped_exit cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (my_at < 0 && bus.phase === 4'd3) my_at = i;
      adv();
    end
    // MG_LOAD at cycle 1; early MY_LOAD MinGreen+1 cycles later.
    n_chk++;
    if (my_at != 1 + int'(MinGreen) + 1) begin
      n_err++;
      $display("FAIL ped_exit_time got=%0d exp=%0d", my_at, 1 + MinGreen + 1);
    end
  endtask

  task automatic test_enable_freeze();
    int  my_hold;
    bit  deferred;
    bit  e;
    my_hold = 3; deferred = 0;
    do_reset();
    g_len = 15; y_len = 3;
    for (int i = 0; i < 45; i++) begin
      e = !(i >= 6 && i < 10);
      if (m_code == 3 && my_hold > 0) begin
        e = 1'b0;
        my_hold--;
        deferred = 1;
      end
      drive(e, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL freeze cyc=%0d en=%0b got=%b exp=%b", i, e, dut_vec(), exp_vec());
      end
      if (deferred && e && m_code == 3) begin
        deferred = 0;
        n_chk++;
        if (bus.init !== 3'b010) begin
          n_err++;
          $display("FAIL freeze_deferred_init got=%b exp=010", bus.init);
        end
      end
      adv();
    end
  endtask

  task automatic test_simultaneous();
    int my_at;
    my_at = -1;
    do_reset();
    g_len = int'(MinGreen); y_len = 3;
    for (int i = 0; i < 30; i++) begin
      drive(1'b1, (i == 3), 1'b1);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL simultaneous cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      if (my_at < 0 && bus.phase === 4'd3) my_at = i;
      if (my_at >= 0 && i == my_at + 1) begin
        n_chk++;
        if (bus.phase !== 4'd4) begin
          n_err++;
          $display("FAIL simultaneous_next got=%0d exp=4", bus.phase);
        end
      end
      adv();
    end
    n_chk++;
    if (my_at != 1 + int'(MinGreen) + 1) begin
      n_err++;
      $display("FAIL simultaneous_time got=%0d exp=%0d", my_at, 1 + MinGreen + 1);
    end
  endtask

  task automatic test_random();
    do_reset();
    rand_len = 1;
    g_len = $urandom_range(1, 10); y_len = $urandom_range(1, 4);
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 2) == 0));
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      adv();
    end
    rand_len = 0;
  endtask

  task automatic test_async_reset();
    int i;
    do_reset();
    g_len = 15; y_len = 3;
    i = 0;
    while (i < 100 && !(m_code == 6 && c_cnt >= 3)) begin
      drive(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL async_pre cyc=%0d got=%b exp=%b", i, dut_vec(), exp_vec());
      end
      adv();
      i++;
    end
    n_chk++;
    if (m_code != 6) begin
      n_err++;
      $display("FAIL async_reach_sg got=%0d exp=6", m_code);
    end
    bus.en = 1'b1;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (dut_vec() !== ResetVec) begin
      n_err++;
      $display("FAIL async_reset got=%b exp=%b", dut_vec(), ResetVec);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      n_chk++;
      if (dut_vec() !== exp_vec()) begin
        n_err++;
        $display("FAIL async_restart cyc=%0d got=%b exp=%b", k, dut_vec(), exp_vec());
      end
      adv();
    end
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rand_len = 0;
    g_len = 15;
    y_len = 3;
    cur_en = 0; cur_req = 0; cur_last = 0;
    model_reset();
    test_reset();
    test_full_cycle();
    test_ped_early_exit();
    test_enable_freeze();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
